mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
Parametrised N-channel, W-bit registered multiplexer with a sequencer front end.
- Selects one of CHANNELS input words per sample, either by an external select (manual mode) or by an internal round-robin scanner (auto mode).
- Auto mode skips masked-off channels and dwells DWELL samples per channel.
- Output is a registered valid/ready stream tagged with the source channel number.
- Sits between a bank of sampled sources and a single downstream consumer (serialiser/logger).

Parameters:
WIDTH, 8, data bits per channel.
CHANNELS, 4, number of input channels (>=2).
SEL_W, 2, select/channel-tag width; must equal ceil(log2(CHANNELS)).
DWELL, 2, accepted samples per channel before scan advances (>=1).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  sequencer enable; 0 stops new captures.
mode  in  1  0 = manual (sel_in), 1 = auto scan.
sel_in  in  SEL_W  manual channel select.
ch_mask  in  CHANNELS  auto-mode channel enable; bit k = channel k.
din  in  CHANNELS*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH].
y  out  WIDTH  registered selected data.
y_ch  out  SEL_W  channel tag of y.
y_valid  out  1  y/y_ch hold a sample.
y_ready  in  1  downstream accepts when high together with y_valid.
sel_err  out  1  registered; 1 when the current sample came from an out-of-range sel_in.

Behaviour:
- Reset (async, immediate): y=0, y_ch=0, y_valid=0, sel_err=0, state=IDLE, cur_ch=0, dwell_cnt=0.
- Transfer = y_valid & y_ready. Capture slot = en & (!y_valid | y_ready).
- Capture writes y, y_ch, sel_err and sets y_valid=1 on the next clk edge. Latency is 1 cycle from din/select to y.
- Stall: while y_valid & !y_ready, y/y_ch/sel_err stay stable and dwell_cnt is frozen.
- No capture slot while y_valid & !y_ready. If a transfer occurs with no capture, y_valid goes to 0.
- FSM states: IDLE, MANUAL, SCAN.
  - Any state -> IDLE when en=0.
  - IDLE/SCAN -> MANUAL when en=1 & mode=0.
  - IDLE/MANUAL -> SCAN when en=1 & mode=1.
  - Transitions are evaluated every cycle. A pending y is never discarded by a transition.
- IDLE: no captures. y_valid drops only after its pending transfer.
- MANUAL: at each capture slot, y=din[sel_in], y_ch=sel_in, sel_err=0.
  - If sel_in >= CHANNELS: y=0, y_ch=sel_in, sel_err=1; y_valid still asserted.
- SCAN entry: cur_ch = lowest set bit of ch_mask, dwell_cnt=0.
- SCAN, each capture slot: y=din[cur_ch], y_ch=cur_ch, sel_err=0.
- SCAN, on each transfer of a scan sample: dwell_cnt++.
  - When dwell_cnt reaches DWELL-1 and is accepted: dwell_cnt=0 and cur_ch advances to the next set bit of ch_mask above cur_ch, wrapping from CHANNELS-1 to 0.
  - If only one bit is set, cur_ch stays on that channel.
- ch_mask=0 in SCAN: no captures. y_valid clears after the pending transfer. FSM stays in SCAN.
  - When the mask becomes nonzero, resume at the lowest set bit.
- Mask change mid-dwell: if cur_ch is no longer enabled, the next capture uses the next enabled channel above cur_ch (with wrap) and dwell_cnt resets to 0.
- Simultaneous transfer and capture in the same cycle: new sample replaces old, y_valid stays 1 (full throughput, one sample per clk).
- Reset mid-operation: all state is cleared immediately; a pending sample is lost.

Optional Feature:
MUX_SCAN_PARITY_EN.
- Defined: adds output port y_par (1 bit, reset 0), registered with y. Value is even parity of y (XOR of all bits). Held during stall like y.
- Undefined: port y_par is absent; no parity logic.

Test Plan:
1. Manual select: din ch0..3 = 8'hA0, 8'hA1, 8'hA2, 8'hA3; en=1, mode=0, y_ready=1; sel_in 0->1->2->3 one per clk -> y=A0,A1,A2,A3 each one cycle later; y_ch matches; y_valid=1 continuous.
2. Scan with dwell: mode=1, ch_mask=4'b1111, DWELL=2, y_ready=1 -> y_ch sequence 0,0,1,1,2,2,3,3,0,0; y follows din of tagged channel.
3. Masked scan and wrap: ch_mask=4'b1010 -> y_ch 1,1,3,3,1,1. Then ch_mask=0 -> y_valid=0 within 1 cycle of the last transfer.
4. Backpressure: scan, y_ready=0 for 5 cycles mid-dwell -> y, y_ch stable, y_valid=1, no channel advance; y_ready=1 resumes the exact sequence.
5. Out-of-range select: build with CHANNELS=3, SEL_W=2, mode=0, sel_in=3 -> y=0, y_ch=3, sel_err=1, y_valid=1; sel_in=1 next -> sel_err=0.
6. Async reset: assert rst mid-scan between clk edges -> y=0, y_ch=0, y_valid=0, sel_err=0 immediately. Release with en=1, mode=1, ch_mask=4'b0100 -> first sample y_ch=2.

Source files
------------

// File: rtl/mux_scan_seq.sv
// N-channel registered mux with manual select or masked round-robin scan, valid/ready output.
// Define MUX_SCAN_PARITY_EN to add the y_par output (even parity of y).
module mux_scan_seq #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  input  logic                      y_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic                      y_par,
`endif
  output logic                      sel_err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_y;
  logic [SEL_W-1:0]   r_y_ch;
  logic               r_valid;
  logic               r_err;
  logic [SEL_W-1:0]   r_cur_ch;
  logic [DW_W-1:0]    r_dwell;
  logic               r_restart;

  logic               w_slot;
  logic               w_mask_any;
  logic               w_cap_man;
  logic               w_cap_scan;
  logic               w_capture;
  logic               w_cur_ok;
  logic [SEL_W-1:0]   w_scan_ch;
  logic [DW_W-1:0]    w_scan_dwell;
  logic [SEL_W-1:0]   w_mux_ch;
  logic [WIDTH-1:0]   w_mux_data;
  logic               w_mux_ok;

  // Next enabled channel strictly above base, wrapping; returns base itself last.
  function automatic logic [SEL_W-1:0] nextSet(input logic [CHANNELS-1:0] mask,
                                               input logic [SEL_W-1:0] base);
    logic [SEL_W-1:0] res;
    logic             found;
    res   = base;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      int idx;
      idx = int'(base) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && mask[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!en)       w_next_state = IDLE;
    else if (mode) w_next_state = SCAN;
    else           w_next_state = MANUAL;
  end

  assign w_slot     = en & (~r_valid | y_ready);
  assign w_mask_any = |ch_mask;
  assign w_cap_man  = w_slot & (r_state == MANUAL);
  assign w_cap_scan = w_slot & (r_state == SCAN) & w_mask_any;
  assign w_capture  = w_cap_man | w_cap_scan;

  // A restart or a channel masked out mid-dwell both begin a fresh dwell.
  assign w_cur_ok     = ch_mask[r_cur_ch];
  assign w_scan_ch    = r_restart ? nextSet(ch_mask, SEL_W'(CHANNELS-1))
                      : (w_cur_ok ? r_cur_ch : nextSet(ch_mask, r_cur_ch));
  assign w_scan_dwell = (r_restart | ~w_cur_ok) ? '0 : r_dwell;
  assign w_mux_ch     = (r_state == SCAN) ? w_scan_ch : sel_in;

  always_comb begin
    w_mux_data = '0;
    w_mux_ok   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_mux_ch == SEL_W'(k)) begin
        w_mux_data = din[k*WIDTH +: WIDTH];
        w_mux_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_y_ch  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_y     <= w_mux_ok ? w_mux_data : '0;
      r_y_ch  <= w_mux_ch;
      r_err   <= ~w_mux_ok;
      r_valid <= 1'b1;
    end else if (y_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Dwell is charged when a scan sample is taken; a taken sample is always delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_ch  <= '0;
      r_dwell   <= '0;
      r_restart <= 1'b0;
    end else if (r_state != SCAN && w_next_state == SCAN) begin
      r_cur_ch  <= '0;
      r_dwell   <= '0;
      r_restart <= 1'b1;
    end else if (r_state == SCAN && !w_mask_any) begin
      r_restart <= 1'b1;
    end else if (w_cap_scan) begin
      r_restart <= 1'b0;
      if (w_scan_dwell == DW_W'(DWELL-1)) begin
        r_dwell  <= '0;
        r_cur_ch <= nextSet(ch_mask, w_scan_ch);
      end else begin
        r_dwell  <= w_scan_dwell + 1'b1;
        r_cur_ch <= w_scan_ch;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_par <= 1'b0;
    else if (w_capture) r_par <= w_mux_ok ? ^w_mux_data : 1'b0;
  end

  assign y_par = r_par;
`endif

  assign y       = r_y;
  assign y_ch    = r_y_ch;
  assign y_valid = r_valid;
  assign sel_err = r_err;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: vector table for manual/scan/backpressure,
// hand sequences for out-of-range select (3-channel build) and async reset.
module tb_mux_scan_seq;

  logic        clk;
  logic        rst;
  logic        en, mode, yReady;
  logic [1:0]  selIn;
  logic [3:0]  chMask;
  logic [31:0] din;
  logic [7:0]  y;
  logic [1:0]  yCh;
  logic        yValid, selErr;

  logic        en3, mode3, yReady3;
  logic [1:0]  selIn3;
  logic [2:0]  chMask3;
  logic [23:0] din3;
  logic [7:0]  y3;
  logic [1:0]  yCh3;
  logic        yValid3, selErr3;

`ifdef MUX_SCAN_PARITY_EN
  logic        yPar, yPar3;
`endif

  int nChecks = 0;
  int nErrors = 0;

  mux_scan_seq #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(selIn), .ch_mask(chMask),
    .din(din), .y(y), .y_ch(yCh), .y_valid(yValid), .y_ready(yReady),
`ifdef MUX_SCAN_PARITY_EN
    .y_par(yPar),
`endif
    .sel_err(selErr)
  );

  mux_scan_seq #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .mode(mode3), .sel_in(selIn3), .ch_mask(chMask3),
    .din(din3), .y(y3), .y_ch(yCh3), .y_valid(yValid3), .y_ready(yReady3),
`ifdef MUX_SCAN_PARITY_EN
    .y_par(yPar3),
`endif
    .sel_err(selErr3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] mask;
    logic       ready;
    logic       expValid;
    logic [7:0] expY;
    logic [1:0] expCh;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic e, input logic m, input logic [1:0] s,
                        input logic [3:0] mk, input logic r, input logic ev,
                        input logic [7:0] ey, input logic [1:0] ec, input logic ee);
    vec_t v;
    v.en = e; v.mode = m; v.sel = s; v.mask = mk; v.ready = r;
    v.expValid = ev; v.expY = ey; v.expCh = ec; v.expErr = ee;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en     = v.en;
    mode   = v.mode;
    selIn  = v.sel;
    chMask = v.mask;
    yReady = v.ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en = 0; mode = 0; selIn = 0; chMask = 0; yReady = 1;
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    en3 = 0; mode3 = 0; selIn3 = 0; chMask3 = 0; yReady3 = 1;
    din3 = {8'h32, 8'h31, 8'h30};

    // Row order: en mode sel mask ready | valid y ch err
    addVec(1,0,0,4'h0,1, 0,8'h00,0,0);
    addVec(1,0,0,4'h0,1, 1,8'hA0,0,0);
    addVec(1,0,1,4'h0,1, 1,8'hA1,1,0);
    addVec(1,0,2,4'h0,1, 1,8'hA2,2,0);
    addVec(1,0,3,4'h0,1, 1,8'hA3,3,0);
    addVec(1,1,3,4'hF,1, 1,8'hA3,3,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    addVec(1,1,0,4'hF,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hF,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hF,1, 1,8'hA2,2,0);
    addVec(1,1,0,4'hF,1, 1,8'hA2,2,0);
    addVec(1,1,0,4'hF,1, 1,8'hA3,3,0);
    addVec(1,1,0,4'hF,1, 1,8'hA3,3,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    addVec(1,1,0,4'hA,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hA,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hA,1, 1,8'hA3,3,0);
    addVec(1,1,0,4'hA,1, 1,8'hA3,3,0);
    addVec(1,1,0,4'hA,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hA,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'h0,1, 0,8'hA1,1,0);
    addVec(1,1,0,4'h0,1, 0,8'hA1,1,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    for (int i = 0; i < 5; i++) addVec(1,1,0,4'hF,0, 1,8'hA0,0,0);
    addVec(1,1,0,4'hF,1, 1,8'hA0,0,0);
    addVec(1,1,0,4'hF,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hF,1, 1,8'hA1,1,0);
    addVec(1,1,0,4'hF,1, 1,8'hA2,2,0);
    addVec(0,1,0,4'hF,1, 0,8'hA2,2,0);

    #3;
    checkOutput("reset_y", 32'(y), 32'h0);
    checkOutput("reset_ch", 32'(yCh), 32'h0);
    checkOutput("reset_valid", 32'(yValid), 32'h0);
    checkOutput("reset_err", 32'(selErr), 32'h0);
    #9 rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_valid", i), 32'(yValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].expY));
      checkOutput($sformatf("vec%0d_ch", i), 32'(yCh), 32'(vecs[i].expCh));
      checkOutput($sformatf("vec%0d_err", i), 32'(selErr), 32'(vecs[i].expErr));
`ifdef MUX_SCAN_PARITY_EN
      checkOutput($sformatf("vec%0d_par", i), 32'(yPar), 32'(^vecs[i].expY));
`endif
    end

    // Out-of-range manual select on the 3-channel build.
    en3 = 1; mode3 = 0; selIn3 = 3; yReady3 = 1;
    step();
    checkOutput("oor_idle_valid", 32'(yValid3), 32'h0);
    step();
    checkOutput("oor_y", 32'(y3), 32'h0);
    checkOutput("oor_ch", 32'(yCh3), 32'h3);
    checkOutput("oor_err", 32'(selErr3), 32'h1);
    checkOutput("oor_valid", 32'(yValid3), 32'h1);
    selIn3 = 1;
    step();
    checkOutput("sel1_y", 32'(y3), 32'h31);
    checkOutput("sel1_ch", 32'(yCh3), 32'h1);
    checkOutput("sel1_err", 32'(selErr3), 32'h0);
    en3 = 0;

    // Async reset between edges mid-scan, then restart on a single-channel mask.
    en = 1; mode = 1; chMask = 4'hF; yReady = 1;
    step();
    step();
    step();
    checkOutput("prerst_valid", 32'(yValid), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncrst_y", 32'(y), 32'h0);
    checkOutput("asyncrst_ch", 32'(yCh), 32'h0);
    checkOutput("asyncrst_valid", 32'(yValid), 32'h0);
    checkOutput("asyncrst_err", 32'(selErr), 32'h0);
    chMask = 4'b0100;
    #2 rst = 1'b0;
    step();
    checkOutput("rel_entry_valid", 32'(yValid), 32'h0);
    step();
    checkOutput("rel_first_valid", 32'(yValid), 32'h1);
    checkOutput("rel_first_ch", 32'(yCh), 32'h2);
    checkOutput("rel_first_y", 32'(y), 32'hA2);
    step();
    checkOutput("rel_second_ch", 32'(yCh), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
